instr_fetch: RTL

Instruction fetch stage directly upstream of the decoder. It holds the fetch PC and issues sequential word requests to instruction memory. Returned words are buffered with their PCs in a small FIFO and presented to the decoder over a valid/ready handshake. A redirect from execute (branch or jump) restarts fetch at a new PC, flushes buffered words and discards in-flight responses.

---
 rtl/instr_fetch.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage that sits directly in front of the decoder. It keeps
// the fetch PC and sends sequential word requests to instruction memory.
// Returned words are stored with their PCs in a small FIFO and handed to the
// decoder over a valid/ready handshake. A redirect from execute restarts fetch
// at a new PC, flushes the buffer and drops responses that are still in flight.
//
// Flow control is credit based. A request is only issued while
// outstanding + fifo_count < FIFO_DEPTH, so every response has a free slot.
//
// Optional build macro:
//   FETCH_PERF_EN  adds the perf_stall_cnt / perf_flush_cnt counter outputs.
//
// Parameters:
//   RESET_PC    fetch PC loaded on reset
//   FIFO_DEPTH  buffer entries and maximum requests in flight
//               (power of two, at least 2)
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   imem_req_valid      fetch request valid
//   imem_req_ready      memory accepts the request
//   imem_req_addr       word-aligned fetch address (always the fetch PC)
//   imem_rsp_valid      in-order response valid, no backpressure
//   imem_rsp_data       returned instruction word
//   redirect_valid      single-cycle restart pulse from execute
//   redirect_pc         restart target (low two bits ignored)
//   instr_valid         buffered instruction available to the decoder
//   instr_ready         decoder accepts the instruction
//   instr, instr_pc     instruction word at the FIFO head and its PC
//   perf_stall_cnt      (FETCH_PERF_EN) cycles with instr_ready && !instr_valid
//   perf_flush_cnt      (FETCH_PERF_EN) number of redirects
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  // Architectural state
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic          active;

  logic [31:0] buf_data [FIFO_DEPTH];
  logic [31:0] buf_pc   [FIFO_DEPTH];

  // Per-cycle events
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   redirect_target;

  // The low address bits of a redirect are forced to zero.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};

  // Requests stay off until the first edge after reset release, so the
  // reset state shows imem_req_valid low. A redirect withdraws any pending
  // request for its cycle.
  assign imem_req_valid = active && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, count}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is dropped while discard is non-zero. In a redirect cycle it
  // is not pushed either, because the buffer is being flushed.
  assign rsp_drop = imem_rsp_valid && (discard != '0);
  assign push     = imem_rsp_valid && (discard == '0) && !redirect_valid;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instr       = buf_data[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  // Requests still unreturned after this cycle's accept and response.
  always_comb begin
    // NOTE: assign every combinational output a default first; a path that
    // leaves it unassigned would infer a latch.
    outstanding_nxt = outstanding;
    if (req_fire && !imem_rsp_valid) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!req_fire && imem_rsp_valid) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // Control state. A redirect has priority over every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      active      <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments, so
      // every register here samples the values from before this edge.
      active      <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        // Everything still in flight belongs to the old stream. A response
        // in this same cycle has already been counted out.
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_drop) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (!push && pop) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  // Buffer storage. The head entry drives instr / instr_pc directly, so the
  // decoder never sees a combinational path from the memory bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this buffer is only FIFO_DEPTH entries deep, so it is reset to
      // give instr / instr_pc a defined zero value after reset; a large
      // memory would normally be left unreset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running event counters that wrap on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (instr_ready && !instr_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (redirect_valid) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
